// File: rtl/vlsu_vrf_wr_arbiter_if.sv
// rtl/vlsu_vrf_wr_arbiter_if.sv - requester and VRF-side bundle for the per-lane write-port arbiter
interface vlsu_vrf_wr_arbiter_if #(
    parameter int unsigned NrExits   = 4,
    parameter int unsigned NrReq     = 2,
    parameter type         tx_lane_t = logic
);
    // Requester side, one beat per requester per lane
    logic [NrReq-1:0][NrExits-1:0] reqs_valid_i;
    logic [NrReq-1:0][NrExits-1:0] reqs_ready_o;
    tx_lane_t                      reqs_i [NrReq][NrExits];

    // VRF side, one registered slot per lane
    logic [NrExits-1:0]            vrf_valid_o;
    logic [NrExits-1:0]            vrf_ready_i;
    tx_lane_t                      vrf_o [NrExits];

    logic                          idle_o;

    // Environment view: drives requests and the VRF ready
    modport master (
        output reqs_valid_i,
        output reqs_i,
        output vrf_ready_i,
        input  reqs_ready_o,
        input  vrf_valid_o,
        input  vrf_o,
        input  idle_o
    );

    // Arbiter view
    modport slave (
        input  reqs_valid_i,
        input  reqs_i,
        input  vrf_ready_i,
        output reqs_ready_o,
        output vrf_valid_o,
        output vrf_o,
        output idle_o
    );
endinterface

// File: rtl/vlsu_vrf_wr_arbiter.sv
// rtl/vlsu_vrf_wr_arbiter.sv - per-lane round-robin VRF write-port arbiter with burst stickiness
module vlsu_vrf_wr_arbiter #(
    parameter int unsigned NrExits   = 4,
    parameter int unsigned NrReq     = 2,
    parameter int unsigned MaxBurst  = 4,
    parameter type         tx_lane_t = logic
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    vlsu_vrf_wr_arbiter_if.slave    bus
);

    localparam int unsigned GntW = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    logic [NrExits-1:0] out_valid_vec;

    for (genvar l = 0; l < NrExits; l++) begin : g_lane
        logic              out_valid_q;
        tx_lane_t          out_data_q;
        logic [GntW-1:0]   last_gnt_q;
        logic [CntW-1:0]   burst_cnt_q;

        logic [NrReq-1:0]  valid_vec;
        logic              can_load;
        logic              any_v;
        logic              accept;
        logic [GntW-1:0]   winner;

        // Gather this lane's request valids into one vector
        always_comb begin
            valid_vec = '0;
            for (int r = 0; r < NrReq; r++) begin
                valid_vec[r] = bus.reqs_valid_i[r][l];
            end
        end

        assign can_load = !out_valid_q || bus.vrf_ready_i[l];
        assign any_v    = |valid_vec;
        assign accept   = can_load && any_v;

        // Pick the winner: stay with the last grantee while its burst window
        // is open, otherwise scan forward from last_gnt+1, wrapping onto
        // last_gnt itself as the final candidate
        always_comb begin
            logic            found;
            logic [GntW-1:0] cand;
            winner = last_gnt_q;
            found  = 1'b0;
            cand   = '0;
            if (valid_vec[last_gnt_q] && (burst_cnt_q < CntW'(MaxBurst))) begin
                winner = last_gnt_q;
            end else begin
                for (int k = 1; k <= NrReq; k++) begin
                    cand = GntW'((int'(last_gnt_q) + k) % NrReq);
                    if (!found && valid_vec[cand]) begin
                        winner = cand;
                        found  = 1'b1;
                    end
                end
            end
        end

        for (genvar r = 0; r < NrReq; r++) begin : g_rdy
            assign bus.reqs_ready_o[r][l] = accept && (winner == GntW'(r));
        end

        assign bus.vrf_valid_o[l] = out_valid_q;
        assign bus.vrf_o[l]       = out_data_q;
        assign out_valid_vec[l]   = out_valid_q;

        // Output slot and arbitration state; a stalled full slot freezes
        // everything, an idle cycle closes the current burst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                last_gnt_q  <= '0;
                burst_cnt_q <= '0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.reqs_i[winner][l];
                if (winner == last_gnt_q) begin
                    if (burst_cnt_q < CntW'(MaxBurst)) begin
                        burst_cnt_q <= burst_cnt_q + CntW'(1);
                    end
                end else begin
                    burst_cnt_q <= CntW'(1);
                    last_gnt_q  <= winner;
                end
            end else begin
                if (bus.vrf_ready_i[l]) begin
                    out_valid_q <= 1'b0;
                end
                if (!any_v) begin
                    burst_cnt_q <= '0;
                end
            end
        end
    end

    assign bus.idle_o = !(|out_valid_vec) && !(|bus.reqs_valid_i);

endmodule

// File: tb/tb_vlsu_vrf_wr_arbiter.sv
// tb/tb_vlsu_vrf_wr_arbiter.sv - randomized and directed self-checking bench for vlsu_vrf_wr_arbiter
module tb_vlsu_vrf_wr_arbiter;

    localparam int NE  = 4;
    localparam int NRR = 2;
    localparam int MB  = 4;

    typedef logic [7:0] beat_t;

    logic clk_i;
    logic rst_ni;

    vlsu_vrf_wr_arbiter_if #(.NrExits(NE), .NrReq(NRR), .tx_lane_t(beat_t)) bus ();

    vlsu_vrf_wr_arbiter #(
        .NrExits  (NE),
        .NrReq    (NRR),
        .MaxBurst (MB),
        .tx_lane_t(beat_t)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per lane, the slot contents plus who owns the port and for how long
    int    m_owner [NE];
    int    m_run   [NE];
    bit    m_full  [NE];
    beat_t m_beat  [NE];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NE; l++) begin
            m_owner[l] = 0;
            m_run[l]   = 0;
            m_full[l]  = 0;
            m_beat[l]  = '0;
        end
    endtask

    // Current owner keeps the port while it asks and its run is short enough;
    // otherwise the next asking requester in ring order after the owner takes it
    function automatic int pick(int l);
        if (bus.reqs_valid_i[m_owner[l]][l] && m_run[l] < MB) return m_owner[l];
        for (int k = 1; k <= NRR; k++) begin
            int c;
            c = (m_owner[l] + k) % NRR;
            if (bus.reqs_valid_i[c][l]) return c;
        end
        return -1;
    endfunction

    task automatic rand_payload();
        for (int r = 0; r < NRR; r++)
            for (int l = 0; l < NE; l++)
                bus.reqs_i[r][l] = beat_t'($urandom);
    endtask

    // Called just after a falling edge: apply inputs and let them settle
    task automatic drive(input logic [NRR-1:0][NE-1:0] v, input logic [NE-1:0] rdy);
        bus.reqs_valid_i = v;
        bus.vrf_ready_i  = rdy;
        #1;
    endtask

    // Compare DUT against the model, advance the model across the next rising edge
    task automatic settle();
        bit any_full;
        any_full = 0;
        for (int l = 0; l < NE; l++) begin
            int w;
            bit take;
            logic [NRR-1:0] exp_r, got_r;
            w    = pick(l);
            take = (!m_full[l] || bus.vrf_ready_i[l]) && (w >= 0);
            for (int r = 0; r < NRR; r++) begin
                exp_r[r] = take && (r == w);
                got_r[r] = bus.reqs_ready_o[r][l];
            end
            check_eq($sformatf("ready_l%0d", l), 32'(got_r), 32'(exp_r));
            check_eq($sformatf("vvalid_l%0d", l), 32'(bus.vrf_valid_o[l]), 32'(m_full[l]));
            if (m_full[l]) check_eq($sformatf("vdata_l%0d", l), 32'(bus.vrf_o[l]), 32'(m_beat[l]));
            if (m_full[l]) any_full = 1;
        end
        check_eq("idle", 32'(bus.idle_o), 32'(!any_full && (bus.reqs_valid_i == '0)));
        for (int l = 0; l < NE; l++) begin
            int w;
            w = pick(l);
            if ((!m_full[l] || bus.vrf_ready_i[l]) && (w >= 0)) begin
                m_beat[l] = bus.reqs_i[w][l];
                m_full[l] = 1;
                if (w == m_owner[l]) begin
                    m_run[l] = (m_run[l] + 1 > MB) ? MB : m_run[l] + 1;
                end else begin
                    m_owner[l] = w;
                    m_run[l]   = 1;
                end
            end else begin
                if (bus.vrf_ready_i[l]) m_full[l] = 0;
                if (w < 0) m_run[l] = 0;
            end
        end
        @(negedge clk_i);
    endtask

    logic [NRR-1:0][NE-1:0] v;
    beat_t                  held;

    initial begin
        rst_ni           = 1'b0;
        bus.reqs_valid_i = '0;
        bus.vrf_ready_i  = '0;
        for (int r = 0; r < NRR; r++)
            for (int l = 0; l < NE; l++)
                bus.reqs_i[r][l] = '0;
        model_reset();
        repeat (2) @(negedge clk_i);

        // Reset state
        check_eq("rst_vvalid", 32'(bus.vrf_valid_o), 32'h0);
        check_eq("rst_idle", 32'(bus.idle_o), 32'h1);
        check_eq("rst_ready", 32'(bus.reqs_ready_o), 32'h0);
        for (int l = 0; l < NE; l++) check_eq("rst_vdata", 32'(bus.vrf_o[l]), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Burst fairness on lane 1: 0,0,0,0,1,1,1,1,0,0,0,0
        for (int i = 0; i < 12; i++) begin
            rand_payload();
            v = '0; v[0][1] = 1'b1; v[1][1] = 1'b1;
            drive(v, '1);
            check_eq("fair_grant", 32'(bus.reqs_ready_o[(i / 4) % 2][1]), 32'h1);
            settle();
        end

        // Single-requester stream on lane 0, data 0..7
        for (int i = 0; i < 9; i++) begin
            v = '0;
            if (i < 8) begin
                v[0][0] = 1'b1;
                bus.reqs_i[0][0] = beat_t'(i);
            end
            drive(v, '1);
            if (i > 0) begin
                check_eq("stream_valid", 32'(bus.vrf_valid_o[0]), 32'h1);
                check_eq("stream_data", 32'(bus.vrf_o[0]), 32'(i - 1));
            end
            check_eq("stream_l2_quiet", 32'(bus.vrf_valid_o[2]), 32'h0);
            check_eq("stream_l3_quiet", 32'(bus.vrf_valid_o[3]), 32'h0);
            settle();
        end

        // Yield on drop, lane 3: 0,0 then requester 1 takes over, then stays sticky
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            v = '0; v[1][3] = 1'b1; v[0][3] = (i != 2);
            drive(v, '1);
            check_eq("yield_grant", 32'(bus.reqs_ready_o[(i >= 2) ? 1 : 0][3]), 32'h1);
            settle();
        end

        // Burst break, lane 2: 2 beats, idle, then both -> 0,0,0,0,1
        for (int i = 0; i < 8; i++) begin
            rand_payload();
            v = '0;
            if (i < 2) v[0][2] = 1'b1;
            if (i >= 3) begin v[0][2] = 1'b1; v[1][2] = 1'b1; end
            drive(v, '1);
            if (i == 2) check_eq("break_idle", 32'(bus.reqs_ready_o[0][2] | bus.reqs_ready_o[1][2]), 32'h0);
            else        check_eq("break_grant", 32'(bus.reqs_ready_o[(i == 7) ? 1 : 0][2]), 32'h1);
            settle();
        end

        // Backpressure on lane 2 while lane 3 streams
        rand_payload();
        v = '0; v[0][2] = 1'b1;
        drive(v, '1);
        settle();
        held = m_beat[2];
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            v = '0; v[0][2] = 1'b1; v[1][2] = 1'b1; v[0][3] = 1'b1;
            drive(v, 4'b1011);
            check_eq("bp_ready_l2", 32'(bus.reqs_ready_o[0][2] | bus.reqs_ready_o[1][2]), 32'h0);
            check_eq("bp_hold_l2", 32'(bus.vrf_o[2]), 32'(held));
            check_eq("bp_valid_l2", 32'(bus.vrf_valid_o[2]), 32'h1);
            check_eq("bp_stream_l3", 32'(bus.reqs_ready_o[0][3]), 32'h1);
            settle();
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            v = ($urandom_range(0, 9) == 0) ? '0 : (NRR * NE)'($urandom);
            drive(v, ($urandom_range(0, 2) == 0) ? NE'($urandom) : '1);
            settle();
        end

        // Reset in the middle of a full, stalled pipeline
        for (int i = 0; i < 2; i++) begin
            rand_payload();
            drive('1, '0);
            settle();
        end
        check_eq("pre_rst_full", 32'(bus.vrf_valid_o), 32'hF);
        drive('1, '0);
        rst_ni = 1'b0;
        #1;
        check_eq("rst_async_vvalid", 32'(bus.vrf_valid_o), 32'h0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rand_payload();
        drive('1, '1);
        for (int l = 0; l < NE; l++) check_eq("post_rst_grant0", 32'(bus.reqs_ready_o[0][l]), 32'h1);
        settle();
        for (int i = 0; i < 20; i++) begin
            rand_payload();
            drive((NRR * NE)'($urandom), NE'($urandom));
            settle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
